root_hub_controller: RTL and testbench

Parametrised test-case sequencer for the root hub. It issues a START_DECODING broadcast, then NUM_FUSION_STAGES measurement-data headers, and collects one result per leaf with a per-leaf bitmap, timeout recovery and error counting. It sits between the local TX/RX FIFOs of the root hub core (channel 0) and replaces the fixed single/dual-stage test driver used in full-system benches.

---
 rtl/root_hub_controller_pkg.sv | 28 ++
 rtl/leaf_result_tracker.sv | 48 ++++
 rtl/root_hub_controller.sv | 165 ++++++++++++++++
 tb/tb_root_hub_controller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/root_hub_controller_pkg.sv
// Shared constants for the root hub test-case sequencer: message types, field positions,
// FSM state encoding and the outgoing-message builder.
package root_hub_controller_pkg;

  localparam logic [7:0] START_DECODING_MSG      = 8'h01;
  localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

  localparam logic [15:0] BROADCAST_DEST = 16'hFFFF;

  // Incoming result fields
  localparam int unsigned SRC_MSB  = 55;
  localparam int unsigned SRC_LSB  = 48;
  localparam int unsigned ITER_MSB = 47;
  localparam int unsigned ITER_LSB = 40;
  localparam int unsigned CYC_MSB  = 39;
  localparam int unsigned CYC_LSB  = 24;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] START  = 2'd1;
  localparam logic [1:0] HEADER = 2'd2;
  localparam logic [1:0] WAIT   = 2'd3;

  // [63:48] destination, [47:40] type, [7:0] payload, everything else zero
  function automatic logic [63:0] make_msg(input logic [7:0] msg_type, input logic [7:0] payload);
    return {BROADCAST_DEST, msg_type, 32'h0, payload};
  endfunction

endpackage

// File: rtl/leaf_result_tracker.sv
// Per-leaf seen bitmap for one test case: flags out-of-range or duplicate result beats and
// reports when the case is complete for the current run mode.
module leaf_result_tracker #(
  parameter int unsigned NUM_LEAVES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       beat_valid,
  input  logic [7:0] id,
  input  logic       mode,
  output logic       accept,
  output logic       error,
  output logic       complete
);

  logic [NUM_LEAVES-1:0] seen_q, seen_d, hit;

  // One-hot decode of the source id; an all-zero hit means out of range
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_LEAVES; i++) begin
      hit[i] = (id == 8'(i));
    end
  end

  assign accept   = beat_valid && (|hit) && !(|(seen_q & hit));
  assign error    = beat_valid && !accept;
  assign complete = accept && (mode || (&(seen_q | hit)));

  always_comb begin
    seen_d = seen_q;
    if (clear) begin
      seen_d = '0;
    end else if (accept) begin
      seen_d = seen_q | hit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen_q <= '0;
    end else begin
      seen_q <= seen_d;
    end
  end

endmodule

// File: rtl/root_hub_controller.sv
// Root hub test-case sequencer: START broadcast, per-stage headers, then result collection
// with timeout. Optional statistics outputs are enabled by defining ROOT_HUB_STATS_EN.
module root_hub_controller
  import root_hub_controller_pkg::*;
#(
  parameter int unsigned NUM_LEAVES        = 1,
  parameter int unsigned MAX_COUNT         = 1000,
  parameter int unsigned NUM_FUSION_STAGES = 1,
  parameter bit          MULTI_FPGA_RUN    = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES    = 65535,
  parameter int unsigned CHANNEL_WIDTH     = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  output logic [CHANNEL_WIDTH-1:0] tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  input  logic [CHANNEL_WIDTH-1:0] rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [31:0]              test_count,
  output logic [31:0]              timeout_count,
  output logic [31:0]              error_count,
  output logic                     done
`ifdef ROOT_HUB_STATS_EN
  ,
  output logic [47:0]              total_cycles,
  output logic [7:0]               max_iterations
`endif
);

  localparam logic [7:0] LastStage = 8'(NUM_FUSION_STAGES - 1);
  localparam logic       FusionOn  = (NUM_FUSION_STAGES > 1);
  localparam logic       Mode      = MULTI_FPGA_RUN;
  localparam bit         TimeoutEn = (TIMEOUT_CYCLES != 0);

  logic [1:0]  state_q, state_d;
  logic [7:0]  stage_q, stage_d;
  logic [31:0] wait_q, wait_d;
  logic [31:0] test_count_q, test_count_d;
  logic [31:0] timeout_count_q, timeout_count_d;
  logic [31:0] error_count_q, error_count_d;
  logic        clear, beat_valid, accept, error, complete;

  assign beat_valid = rx_valid && (state_q == WAIT);

  leaf_result_tracker #(
    .NUM_LEAVES (NUM_LEAVES)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .beat_valid (beat_valid),
    .id         (rx_data[SRC_MSB:SRC_LSB]),
    .mode       (Mode),
    .accept     (accept),
    .error      (error),
    .complete   (complete)
  );

  always_comb begin
    state_d         = state_q;
    stage_d         = stage_q;
    wait_d          = wait_q;
    test_count_d    = test_count_q;
    timeout_count_d = timeout_count_q;
    error_count_d   = error_count_q;
    clear           = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && (test_count_q < MAX_COUNT)) begin
          state_d      = START;
          test_count_d = test_count_q + 32'd1;
          stage_d      = '0;
          wait_d       = '0;
          clear        = 1'b1;
        end
      end
      START: begin
        if (tx_ready) state_d = HEADER;
      end
      HEADER: begin
        if (tx_ready) begin
          if (stage_q == LastStage) state_d = WAIT;
          else                      stage_d = stage_q + 8'd1;
        end
      end
      default: begin
        wait_d = wait_q + 32'd1;
        if (error) error_count_d = error_count_q + 32'd1;
        // A completing beat takes priority over a timeout landing in the same cycle
        if (complete) begin
          state_d = IDLE;
        end else if (TimeoutEn && (wait_d == TIMEOUT_CYCLES)) begin
          state_d         = IDLE;
          timeout_count_d = timeout_count_q + 32'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      stage_q         <= '0;
      wait_q          <= '0;
      test_count_q    <= '0;
      timeout_count_q <= '0;
      error_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      stage_q         <= stage_d;
      wait_q          <= wait_d;
      test_count_q    <= test_count_d;
      timeout_count_q <= timeout_count_d;
      error_count_q   <= error_count_d;
    end
  end

  // Outputs come from registered state only, so stalls cannot disturb tx_data
  always_comb begin
    tx_data = '0;
    case (state_q)
      START:   tx_data = CHANNEL_WIDTH'(make_msg(START_DECODING_MSG, {6'b0, FusionOn, Mode}));
      HEADER:  tx_data = CHANNEL_WIDTH'(make_msg(MEASUREMENT_DATA_HEADER, stage_q));
      default: tx_data = '0;
    endcase
  end

  assign tx_valid      = (state_q == START) || (state_q == HEADER);
  assign rx_ready      = (state_q == WAIT);
  assign test_count    = test_count_q;
  assign timeout_count = timeout_count_q;
  assign error_count   = error_count_q;
  assign done          = (state_q == IDLE) && (test_count_q == MAX_COUNT);

`ifdef ROOT_HUB_STATS_EN
  logic [47:0] total_cycles_q;
  logic [7:0]  max_iter_q;
  logic [48:0] cyc_sum;

  assign cyc_sum = {1'b0, total_cycles_q} + 49'(rx_data[CYC_MSB:CYC_LSB]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_cycles_q <= '0;
      max_iter_q     <= '0;
    end else if (accept) begin
      total_cycles_q <= cyc_sum[48] ? '1 : cyc_sum[47:0];
      if (rx_data[ITER_MSB:ITER_LSB] > max_iter_q) max_iter_q <= rx_data[ITER_MSB:ITER_LSB];
    end
  end

  assign total_cycles   = total_cycles_q;
  assign max_iterations = max_iter_q;

  logic unused_rx;
  assign unused_rx = ^{rx_data[CHANNEL_WIDTH-1:SRC_MSB+1], rx_data[CYC_LSB-1:0]};
`else
  logic unused_rx;
  assign unused_rx = ^{rx_data[CHANNEL_WIDTH-1:SRC_MSB+1], rx_data[ITER_MSB:0]};
`endif

endmodule

// File: tb/tb_root_hub_controller.sv
// Directed bench for root_hub_controller: instance a (3 leaves, 3 stages, timeout 10, mode 0)
// and instance b (2 leaves, 1 stage, MAX_COUNT 4, mode 1, no timeout).
module tb_root_hub_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic        enable_a = 0, tx_ready_a = 0, rx_valid_a = 0;
  logic [63:0] rx_data_a = '0, tx_data_a;
  logic        tx_valid_a, rx_ready_a, done_a;
  logic [31:0] test_count_a, timeout_count_a, error_count_a;

  logic        enable_b = 0, tx_ready_b = 0, rx_valid_b = 0;
  logic [63:0] rx_data_b = '0, tx_data_b;
  logic        tx_valid_b, rx_ready_b, done_b;
  logic [31:0] test_count_b, timeout_count_b, error_count_b;
  int          starts_b = 0;

`ifdef ROOT_HUB_STATS_EN
  logic [47:0] total_cycles_a, total_cycles_b;
  logic [7:0]  max_iterations_a, max_iterations_b;
`endif

  always #5 clk = ~clk;

  root_hub_controller #(
    .NUM_LEAVES (3), .MAX_COUNT (6), .NUM_FUSION_STAGES (3), .MULTI_FPGA_RUN (1'b0),
    .TIMEOUT_CYCLES (10), .CHANNEL_WIDTH (64)
  ) dut_a (
    .clk (clk), .reset (reset), .enable (enable_a),
    .tx_data (tx_data_a), .tx_valid (tx_valid_a), .tx_ready (tx_ready_a),
    .rx_data (rx_data_a), .rx_valid (rx_valid_a), .rx_ready (rx_ready_a),
    .test_count (test_count_a), .timeout_count (timeout_count_a),
    .error_count (error_count_a), .done (done_a)
`ifdef ROOT_HUB_STATS_EN
    , .total_cycles (total_cycles_a), .max_iterations (max_iterations_a)
`endif
  );

  root_hub_controller #(
    .NUM_LEAVES (2), .MAX_COUNT (4), .NUM_FUSION_STAGES (1), .MULTI_FPGA_RUN (1'b1),
    .TIMEOUT_CYCLES (0), .CHANNEL_WIDTH (64)
  ) dut_b (
    .clk (clk), .reset (reset), .enable (enable_b),
    .tx_data (tx_data_b), .tx_valid (tx_valid_b), .tx_ready (tx_ready_b),
    .rx_data (rx_data_b), .rx_valid (rx_valid_b), .rx_ready (rx_ready_b),
    .test_count (test_count_b), .timeout_count (timeout_count_b),
    .error_count (error_count_b), .done (done_b)
`ifdef ROOT_HUB_STATS_EN
    , .total_cycles (total_cycles_b), .max_iterations (max_iterations_b)
`endif
  );

  // Count START handshakes on instance b
  always @(posedge clk) begin
    if (tx_valid_b && tx_ready_b && tx_data_b[47:40] == 8'h01) starts_b <= starts_b + 1;
  end

  function automatic logic [63:0] msg(input logic [7:0] t, input logic [7:0] p);
    return {16'hFFFF, t, 32'h0, p};
  endfunction

  function automatic logic [63:0] beat(input logic [7:0] id);
    return {8'h00, id, 48'h0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_tx_valid", 64'(tx_valid_a), 64'd0);
    chk("rst_tx_data", tx_data_a, 64'd0);
    chk("rst_rx_ready", 64'(rx_ready_a), 64'd0);
    chk("rst_test_count", 64'(test_count_a), 64'd0);
    chk("rst_done_b", 64'(done_b), 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // Case 1: START, headers 0..2 with tx_ready stalls, results 2,0,1
    enable_a = 1; tx_ready_a = 1;
    tick();
    chk("c1_start", tx_data_a, msg(8'h01, 8'h02));
    chk("c1_test_count", 64'(test_count_a), 64'd1);
    chk("c1_done", 64'(done_a), 64'd0);
    enable_a = 0; tx_ready_a = 0;
    tick();
    chk("c1_start_stall", tx_data_a, msg(8'h01, 8'h02));
    tx_ready_a = 1; tick();
    chk("c1_hdr0", tx_data_a, msg(8'h02, 8'h00));
    tx_ready_a = 0; tick();
    chk("c1_hdr0_stall", tx_data_a, msg(8'h02, 8'h00));
    tx_ready_a = 1; tick();
    chk("c1_hdr1", tx_data_a, msg(8'h02, 8'h01));
    tx_ready_a = 0; tick();
    chk("c1_hdr1_stall", tx_data_a, msg(8'h02, 8'h01));
    tx_ready_a = 1; tick();
    chk("c1_hdr2", tx_data_a, msg(8'h02, 8'h02));
    tick();
    chk("c1_wait_rx_ready", 64'(rx_ready_a), 64'd1);
    chk("c1_wait_tx_valid", 64'(tx_valid_a), 64'd0);
    rx_valid_a = 1; rx_data_a = beat(8'd2); tick();
    rx_data_a = beat(8'd0); tick();
    chk("c1_two_of_three", 64'(rx_ready_a), 64'd1);
    rx_data_a = beat(8'd1); tick();
    rx_valid_a = 0;
    chk("c1_idle", 64'(rx_ready_a), 64'd0);
    chk("c1_errors", 64'(error_count_a), 64'd0);

    // Case 2: duplicate and out-of-range beats
    enable_a = 1; tick();
    chk("c2_test_count", 64'(test_count_a), 64'd2);
    enable_a = 0;
    repeat (4) tick();
    rx_valid_a = 1; rx_data_a = beat(8'd1); tick();
    rx_data_a = beat(8'd1); tick();
    rx_data_a = beat(8'd7); tick();
    rx_valid_a = 0; tick();
    chk("c2_errors", 64'(error_count_a), 64'd2);
    chk("c2_still_wait", 64'(rx_ready_a), 64'd1);
    rx_valid_a = 1; rx_data_a = beat(8'd0); tick();
    chk("c2_wait_id2", 64'(rx_ready_a), 64'd1);
    rx_data_a = beat(8'd2); tick();
    rx_valid_a = 0;
    chk("c2_done", 64'(rx_ready_a), 64'd0);
    chk("c2_errors_end", 64'(error_count_a), 64'd2);

    // Case 3: timeout after 10 WAIT cycles, next case starts
    enable_a = 1; tick();
    enable_a = 0;
    repeat (4) tick();
    repeat (9) tick();
    chk("c3_wait10", 64'(rx_ready_a), 64'd1);
    chk("c3_no_timeout_yet", 64'(timeout_count_a), 64'd0);
    enable_a = 1; tick();
    chk("c3_timeout", 64'(timeout_count_a), 64'd1);
    chk("c3_idle", 64'(rx_ready_a), 64'd0);
    tick();
    chk("c3_next_start", tx_data_a, msg(8'h01, 8'h02));
    chk("c3_test_count", 64'(test_count_a), 64'd4);
    enable_a = 0;

    // Case 4: completing beat in WAIT cycle 10 beats the timeout
    repeat (4) tick();
    repeat (7) tick();
    rx_valid_a = 1; rx_data_a = beat(8'd0); tick();
    rx_data_a = beat(8'd1); tick();
    chk("c4_cycle10", 64'(rx_ready_a), 64'd1);
    rx_data_a = beat(8'd2); tick();
    rx_valid_a = 0;
    chk("c4_complete", 64'(rx_ready_a), 64'd0);
    chk("c4_timeout", 64'(timeout_count_a), 64'd1);

    // Case 5: asynchronous reset during HEADER
    enable_a = 1; tick();
    chk("c5_test_count", 64'(test_count_a), 64'd5);
    enable_a = 0; tick(); tick();
    chk("c5_hdr1", tx_data_a, msg(8'h02, 8'h01));
    #2 reset = 1'b0;
    #1;
    chk("c5_rst_tx_valid", 64'(tx_valid_a), 64'd0);
    chk("c5_rst_tx_data", tx_data_a, 64'd0);
    chk("c5_rst_test_count", 64'(test_count_a), 64'd0);
    chk("c5_rst_timeouts", 64'(timeout_count_a), 64'd0);
    chk("c5_rst_errors", 64'(error_count_a), 64'd0);
    reset = 1'b1;
    enable_a = 1; tick();
    chk("c5_restart", tx_data_a, msg(8'h01, 8'h02));
    chk("c5_restart_count", 64'(test_count_a), 64'd1);
    enable_a = 0;

    // Instance b: mode 1, MAX_COUNT 4
    enable_b = 1; tx_ready_b = 1; rx_valid_b = 1; rx_data_b = beat(8'd1);
    tick();
    chk("b_start", tx_data_b, msg(8'h01, 8'h01));
    tick();
    chk("b_hdr0", tx_data_b, msg(8'h02, 8'h00));
    tick();
    chk("b_wait", 64'(rx_ready_b), 64'd1);
    tick();
    chk("b_first_beat_done", 64'(rx_ready_b), 64'd0);
    repeat (20) tick();
    chk("b_done", 64'(done_b), 64'd1);
    chk("b_test_count", 64'(test_count_b), 64'd4);
    chk("b_idle", 64'(tx_valid_b), 64'd0);
    chk("b_starts", 64'(starts_b), 64'd4);
    chk("b_errors", 64'(error_count_b), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
